// File: rtl/kamikaze_pkg.sv
// Shared encodings and helpers for the kamikaze memory arbiter.
// Pure definitions; no logic or timing of its own.
package kamikaze_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [1:0] ARB_IDLE = 2'd0;
   localparam logic [1:0] ARB_BUSY = 2'd1;
   localparam logic [1:0] ARB_GAP  = 2'd2;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_D  = 1'b1;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

   // Consecutive data grants are only counted while fetch is actually waiting.
   function automatic logic [3:0] run_after_d_grant(input logic [3:0] run, input logic if_pending);
      if (!if_pending) begin
         return 4'd0;
      end
      return (run == 4'hF) ? run : run + 4'd1;
   endfunction

endpackage

// File: rtl/kamikaze_arb_grant.sv
// Combinational grant select: data first, fetch forced after MAX_DATA_RUN data grants.
// Zero latency; a fetch whose address is being flushed this cycle is never granted.
module kamikaze_arb_grant #(
   parameter int unsigned MAX_DATA_RUN = 4
) (
   input  logic       i_if_req,
   input  logic       i_d_req,
   input  logic       i_flush,
   input  logic [3:0] i_run,
   output logic       o_grant_if,
   output logic       o_grant_d
);

   localparam logic [3:0] LP_MAX_RUN = 4'(MAX_DATA_RUN);

   logic w_fetch_starved;

   assign w_fetch_starved = i_if_req && (i_run >= LP_MAX_RUN);

   always_comb begin
      o_grant_if = 1'b0;
      o_grant_d  = 1'b0;
      if (i_d_req && !w_fetch_starved) begin
         o_grant_d = 1'b1;
      end else if (i_if_req && !i_flush) begin
         o_grant_if = 1'b1;
      end
   end

endmodule

// File: rtl/kamikaze_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and load/store.
// Issue 1 cycle after request, ready pulse combinational with mem_ready_i, one GAP cycle between issues.
module kamikaze_mem_arbiter
   import kamikaze_pkg::*;
#(
   parameter int unsigned MAX_DATA_RUN = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            if_req_i,
   input  logic [XLEN-1:0] if_addr_i,
   output logic [XLEN-1:0] if_data_o,
   output logic            if_ready_o,
   input  logic            flush_i,
   input  logic            d_req_i,
   input  logic [XLEN-1:0] d_addr_i,
   input  logic [XLEN-1:0] d_wdata_i,
   input  logic [3:0]      d_wstrb_i,
   output logic [XLEN-1:0] d_rdata_o,
   output logic            d_ready_o,
   output logic            mem_valid_o,
   output logic [XLEN-1:0] mem_addr_o,
   output logic [XLEN-1:0] mem_wdata_o,
   output logic [3:0]      mem_wstrb_o,
   input  logic [XLEN-1:0] mem_rdata_i,
   input  logic            mem_ready_i
);

   logic [1:0]      r_state;
   logic            r_owner;
   logic            r_drop;
   logic [3:0]      r_run;
   logic            r_mem_valid;
   logic [XLEN-1:0] r_mem_addr;
   logic [XLEN-1:0] r_mem_wdata;
   logic [3:0]      r_mem_wstrb;

   logic w_grant_if;
   logic w_grant_d;
   logic w_done;
   logic w_unused;

   assign w_unused = &{1'b0, if_addr_i[1:0]};

   kamikaze_arb_grant #(
      .MAX_DATA_RUN (MAX_DATA_RUN)
   ) u_grant (
      .i_if_req   (if_req_i),
      .i_d_req    (d_req_i),
      .i_flush    (flush_i),
      .i_run      (r_run),
      .o_grant_if (w_grant_if),
      .o_grant_d  (w_grant_d)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state     <= ARB_IDLE;
         r_owner     <= OWN_IF;
         r_drop      <= 1'b0;
         r_run       <= 4'd0;
         r_mem_valid <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_wstrb <= 4'd0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_grant_d) begin
                  r_state     <= ARB_BUSY;
                  r_owner     <= OWN_D;
                  r_mem_valid <= 1'b1;
                  r_mem_addr  <= d_addr_i;
                  r_mem_wdata <= d_wdata_i;
                  r_mem_wstrb <= d_wstrb_i;
                  r_run       <= run_after_d_grant(r_run, if_req_i);
               end else if (w_grant_if) begin
                  r_state     <= ARB_BUSY;
                  r_owner     <= OWN_IF;
                  r_mem_valid <= 1'b1;
                  r_mem_addr  <= word_align(if_addr_i);
                  r_mem_wdata <= '0;
                  r_mem_wstrb <= 4'd0;
                  r_run       <= 4'd0;
               end
            end
            ARB_BUSY: begin
               if (mem_ready_i) begin
                  r_state     <= ARB_GAP;
                  r_mem_valid <= 1'b0;
                  r_drop      <= 1'b0;
               end else if (flush_i && (r_owner == OWN_IF)) begin
                  // The memory still owes us a response; swallow it when it comes.
                  r_drop <= 1'b1;
               end
            end
            ARB_GAP: begin
               r_state <= ARB_IDLE;
            end
            default: begin
               r_state <= ARB_IDLE;
            end
         endcase
      end
   end

   assign w_done = (r_state == ARB_BUSY) && mem_ready_i;

   assign d_ready_o  = w_done && (r_owner == OWN_D);
   assign d_rdata_o  = mem_rdata_i;
   assign if_ready_o = w_done && (r_owner == OWN_IF) && !r_drop && !flush_i;
   assign if_data_o  = mem_rdata_i;

   assign mem_valid_o = r_mem_valid;
   assign mem_addr_o  = r_mem_addr;
   assign mem_wdata_o = r_mem_wdata;
   assign mem_wstrb_o = r_mem_wstrb;

   a_single_ready: assert property (@(posedge clk_i) disable iff (!rst_i)
      !(if_ready_o && d_ready_o));

   a_hold_request: assert property (@(posedge clk_i) disable iff (!rst_i)
      (r_state == ARB_BUSY && !mem_ready_i) |=> (mem_valid_o && $stable(mem_addr_o) && $stable(mem_wstrb_o)));

endmodule

// File: doc/kamikaze_mem_arbiter.md
Name: kamikaze_mem_arbiter

Overview:
Shares the core's single 32-bit memory port between the instruction fetch FIFO (pc_mem_o / ir_i / memory_ready_i side) and the load/store unit. One transaction is outstanding at a time; address, write data and strobes are registered. Data accesses have priority, with a bounded-starvation guarantee for fetch. Branch flushes discard in-flight fetch returns so stale words never enter the fetch FIFO.

Parameters:
MAX_DATA_RUN, 4, max consecutive data grants while a fetch request is pending; then one fetch grant is forced (1..15)

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous reset, active-low
if_req_i  input  1  fetch request (fetch FIFO not full)
if_addr_i  input  32  fetch address from the fetch FIFO's pc_mem_o
if_data_o  output  32  fetch read data, to the fetch FIFO's ir_i
if_ready_o  output  1  fetch data valid, to the fetch FIFO's memory_ready_i; one-cycle pulse
flush_i  input  1  branch taken; same signal as the fetch FIFO's branch_i
d_req_i  input  1  load/store request, held until d_ready_o
d_addr_i  input  32  load/store byte address
d_wdata_i  input  32  store data
d_wstrb_i  input  4  byte write strobes; 0 = load
d_rdata_o  output  32  load data
d_ready_o  output  1  load/store complete; one-cycle pulse
mem_valid_o  output  1  memory request valid
mem_addr_o  output  32  memory address
mem_wdata_o  output  32  memory write data
mem_wstrb_o  output  4  memory byte strobes
mem_rdata_i  input  32  memory read data
mem_ready_i  input  1  memory completes current request

Behaviour:
- FSM states: IDLE, BUSY, GAP. Owner register: IF or D. Drop flag: 1 bit. Run counter: 4 bits.
- Reset values: state IDLE, mem_valid_o 0, mem_addr_o 0, mem_wdata_o 0, mem_wstrb_o 0, owner IF, drop 0, run 0. if_ready_o and d_ready_o are 0.
- IDLE grant rules, evaluated each cycle:
  - d_req_i alone: grant D.
  - if_req_i alone: grant IF, unless flush_i is high that cycle, because the address is stale.
  - Both requesting: grant D if run < MAX_DATA_RUN; otherwise grant IF.
- On a grant, the next cycle is BUSY with mem_valid_o=1 and these registered values:
  - D grant: mem_addr_o = d_addr_i, mem_wdata_o = d_wdata_i, mem_wstrb_o = d_wstrb_i.
  - IF grant: mem_addr_o = {if_addr_i[31:2],2'b00}, mem_wstrb_o = 0.
- Run counter:
  - D grant while if_req_i is high: run increments, saturating at 15.
  - IF grant, or any grant with if_req_i low: run clears to 0.
- BUSY: mem_* outputs are held stable until mem_ready_i. On the mem_ready_i cycle:
  - Owner D: d_ready_o=1 and d_rdata_o=mem_rdata_i, combinational in the same cycle.
  - Owner IF with drop=0: if_ready_o=1 and if_data_o=mem_rdata_i, combinational in the same cycle.
  - Owner IF with drop=1: no pulse; the data is discarded.
  - mem_valid_o goes 0 next cycle; next state is GAP; drop clears.
- GAP: exactly one cycle with no grant, then IDLE. Requesters update their address and request on the completion pulse, so the GAP cycle prevents re-issuing a stale address. Minimum issue-to-issue spacing is 3 cycles at zero memory wait.
- flush_i:
  - In BUSY with owner IF: drop is set; completion is still awaited on the memory side.
  - flush_i on the same cycle as an IF completion suppresses if_ready_o.
  - Data transactions and d_ready_o are never affected by flush_i.
- Latency: request seen in IDLE at cycle N gives mem_valid_o at N+1. With mem_ready_i at N+1, the ready pulse is at N+1.
- Reset mid-BUSY: mem_valid_o drops asynchronously. The memory side tolerates an abandoned request.
- No timeout or error response. mem_ready_i outside BUSY is ignored.

Decomposition:
- Shared package kamikaze_pkg holds:
  - state encoding: ARB_IDLE=2'd0, ARB_BUSY=2'd1, ARB_GAP=2'd2;
  - owner encoding: OWN_IF=1'b0, OWN_D=1'b1;
  - width constant XLEN=32.
- One sub-module, kamikaze_arb_grant: combinational grant select from if_req, d_req, flush and run versus MAX_DATA_RUN. It outputs grant_if and grant_d. FSM and registers stay in the top level.

Test Plan:
- Fetch only, mem_ready_i on the first BUSY cycle, if_addr_i=0x00000102: mem_addr_o=0x00000100, mem_wstrb_o=0, if_ready_o pulses 1 cycle with if_data_o=mem_rdata_i; next grant no earlier than 3 cycles after the first.
- Store d_addr_i=0x20, d_wdata_i=0xDEADBEEF, d_wstrb_i=4'b0011, memory waits 2 cycles: mem_* outputs stay stable for 3 BUSY cycles, d_ready_o pulses once, if_ready_o stays 0.
- Both requesting continuously, MAX_DATA_RUN=4: grant order is D,D,D,D,IF,D,D,D,D,IF; run counter observed as 1,2,3,4,0.
- Fetch in BUSY, flush_i pulsed on cycle 1, mem_ready_i on cycle 3: no if_ready_o; the next fetch uses the post-flush if_addr_i.
- flush_i in the same cycle as an IF completion: if_ready_o=0. flush_i during a D transaction: d_ready_o still pulses.
- rst_i asserted low mid-BUSY: mem_valid_o=0 immediately; after release, state is IDLE with run=0 and a new fetch is granted normally.
